// File: rtl/fsm_ones_pkg.sv
// Shared definitions for the ones-sequence detector slice: state encodings
// and default frame geometry reused by the serializer and the detector benches.
package fsm_ones_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_GAP   = 1;
  localparam int unsigned GAP_CNT_W = 4;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out word serializer with forced-zero inter-frame gap,
// feeding the serial data_in of the ones-sequence detectors.
module piso_serializer
  import fsm_ones_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned GAP       = DEF_GAP,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_par,
  input  logic             load,
  output logic             ready,
  output logic             data_out,
  output logic             busy,
  output logic             frame_end
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]     BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       shreg_q, shreg_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [GAP_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic                   ready_d, data_out_d, busy_d, frame_end_d;
  logic                   accept;

  // Next-state datapath; outputs are decoded from the next state so they register cleanly
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    accept    = load & ready;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_SHIFT;
          shreg_d   = data_par;
          bit_cnt_d = BIT_LAST;
        end
      end
      S_SHIFT: begin
        shreg_d   = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
        bit_cnt_d = bit_cnt_q - CNT_W'(1);
        if (bit_cnt_q == '0) begin
          bit_cnt_d = '0;
          if (GAP > 0) begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_LAST;
          end else if (accept) begin
            shreg_d   = data_par;
            bit_cnt_d = BIT_LAST;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          if (accept) begin
            state_d   = S_SHIFT;
            shreg_d   = data_par;
            bit_cnt_d = BIT_LAST;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    data_out_d  = (state_d == S_SHIFT) ? (MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0]) : 1'b0;
    busy_d      = (state_d != S_IDLE);
    frame_end_d = (state_d == S_SHIFT) && (bit_cnt_d == '0);
    // Ready on the final cycle of a frame lets the next word follow with no idle bit
    ready_d     = (state_d == S_IDLE)
                || ((GAP == 0) && frame_end_d)
                || ((state_d == S_GAP) && (gap_cnt_d == '0));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      ready     <= 1'b1;
      data_out  <= 1'b0;
      busy      <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      ready     <= ready_d;
      data_out  <= data_out_d;
      busy      <= busy_d;
      frame_end <= frame_end_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three configurations, directed table and hand
// sequences, then random loads compared against a frame-queue model.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] load;
  logic [7:0] dp [3];
  logic [2:0] rdy, dout, bsy, fe;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // inst 0: GAP=2 MSB first; inst 1: GAP=0 MSB first; inst 2: GAP=1 LSB first
  piso_serializer #(.WIDTH(8), .GAP(2), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .reset(reset), .data_par(dp[0]), .load(load[0]),
    .ready(rdy[0]), .data_out(dout[0]), .busy(bsy[0]), .frame_end(fe[0]));
  piso_serializer #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b1)) u_b (
    .clk(clk), .reset(reset), .data_par(dp[1]), .load(load[1]),
    .ready(rdy[1]), .data_out(dout[1]), .busy(bsy[1]), .frame_end(fe[1]));
  piso_serializer #(.WIDTH(8), .GAP(1), .MSB_FIRST(1'b0)) u_c (
    .clk(clk), .reset(reset), .data_par(dp[2]), .load(load[2]),
    .ready(rdy[2]), .data_out(dout[2]), .busy(bsy[2]), .frame_end(fe[2]));

  function automatic int gap_of(int i);
    return (i == 0) ? 2 : (i == 1) ? 0 : 1;
  endfunction

  function automatic bit msb_of(int i);
    return (i != 2);
  endfunction

  // Reference model: each cycle shows the head of a queue of pending output bits
  typedef struct { bit d; bit fe; } ent_t;
  ent_t mq [3][$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) mq[i].delete();
    end else begin
      for (int i = 0; i < 3; i++) begin
        bit   can_take;
        ent_t e;
        logic [7:0] w;
        can_take = (mq[i].size() <= 1);
        if (mq[i].size() > 0) void'(mq[i].pop_front());
        if (load[i] && can_take) begin
          w = dp[i];
          for (int b = 0; b < 8; b++) begin
            e.d  = msb_of(i) ? w[7-b] : w[b];
            e.fe = (b == 7);
            mq[i].push_back(e);
          end
          for (int g = 0; g < gap_of(i); g++) begin
            e.d  = 1'b0;
            e.fe = 1'b0;
            mq[i].push_back(e);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int i,
                         input logic e_d, input logic e_fe, input logic e_b, input logic e_r);
    chk({tag, "_dout"},  dout[i], e_d);
    chk({tag, "_fe"},    fe[i],   e_fe);
    chk({tag, "_busy"},  bsy[i],  e_b);
    chk({tag, "_ready"}, rdy[i],  e_r);
  endtask

  typedef struct {
    int          inst;
    logic [7:0]  word;
    logic [15:0] exp;   // expected bit stream, first bit in the MSB of the len-bit field
    int          len;
    int          fe_c;
    int          rdy_c;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{0, 8'hE0, 16'(10'b1110000000), 10, 8, 10};
    vecs[1] = '{0, 8'h81, 16'(10'b1000000100), 10, 8, 10};
    vecs[2] = '{1, 8'hB7, 16'(8'b10110111),     8, 8,  8};
    vecs[3] = '{2, 8'h01, 16'(9'b100000000),    9, 8,  9};
    vecs[4] = '{2, 8'h0F, 16'(9'b111100000),    9, 8,  9};

    reset = 1'b0;
    load  = '0;
    for (int i = 0; i < 3; i++) dp[i] = '0;

    // Reset held for two cycles
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) chk_all($sformatf("rst_i%0d", i), i, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    @(negedge clk);

    // Single-word frames from the table
    for (int v = 0; v < 5; v++) begin
      int i;
      i = vecs[v].inst;
      load[i] = 1'b1;
      dp[i]   = vecs[v].word;
      for (int c = 1; c <= vecs[v].len + 1; c++) begin
        @(negedge clk);
        if (c == 1) load[i] = 1'b0;
        if (c <= vecs[v].len)
          chk_all($sformatf("v%0d_c%0d", v, c), i, vecs[v].exp[vecs[v].len - c],
                  1'(c == vecs[v].fe_c), 1'b1, 1'(c == vecs[v].rdy_c));
        else
          chk_all($sformatf("v%0d_idle", v), i, 1'b0, 1'b0, 1'b0, 1'b1);
      end
    end

    // Load while busy is ignored
    load[0] = 1'b1;
    dp[0]   = 8'hFF;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      chk_all($sformatf("busyld_c%0d", c), 0, 1'(c <= 8), 1'(c == 8), 1'(c <= 10), 1'(c >= 10));
      if (c == 1) load[0] = 1'b0;
      if (c == 3) begin load[0] = 1'b1; dp[0] = 8'h00; end
      if (c == 4) load[0] = 1'b0;
    end

    // Back-to-back words with GAP=0 and load held
    begin
      logic [15:0] bb;
      bb = 16'b1011011101101110;
      load[1] = 1'b1;
      dp[1]   = 8'hB7;
      for (int c = 1; c <= 17; c++) begin
        @(negedge clk);
        if (c <= 16)
          chk_all($sformatf("b2b_c%0d", c), 1, bb[16 - c], 1'(c == 8 || c == 16), 1'b1,
                  1'(c == 8 || c == 16));
        else
          chk_all("b2b_idle", 1, 1'b0, 1'b0, 1'b0, 1'b1);
        if (c == 1) dp[1] = 8'h6E;
        if (c == 9) load[1] = 1'b0;
      end
    end

    // Reset asserted asynchronously during bit 4
    @(negedge clk);
    load[0] = 1'b1;
    dp[0]   = 8'hFF;
    @(negedge clk);
    load[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_before_dout", dout[0], 1'b1);
    #1;
    reset = 1'b0;
    #1;
    chk_all("midrst_async", 0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset   = 1'b1;
    load[0] = 1'b1;
    dp[0]   = 8'h0F;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) load[0] = 1'b0;
      chk_all($sformatf("postrst_c%0d", c), 0, 1'(c >= 5 && c <= 8), 1'(c == 8), 1'b1, 1'(c == 10));
    end
    repeat (2) @(negedge clk);

    // Random loads on all three instances against the model
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (mq[i].size() > 0)
          chk_all($sformatf("rnd%0d_i%0d", n, i), i, mq[i][0].d, mq[i][0].fe, 1'b1,
                  1'(mq[i].size() == 1));
        else
          chk_all($sformatf("rnd%0d_i%0d", n, i), i, 1'b0, 1'b0, 1'b0, 1'b1);
        load[i] = ($urandom_range(0, 2) == 0);
        dp[i]   = 8'($urandom);
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out stage that feeds the serial `data_in` input of the ones-sequence detectors (`fsm_ones_moore_2` / `fsm_ones_mealy_2`). It accepts a WIDTH-bit word through a load/ready handshake and emits its bits one per clock, in a configurable bit order. It then inserts GAP forced-zero bits, so consecutive words cannot merge into a false run of ones at the detector. The output is registered and drives the detector directly; no glue logic sits between the two stages.

## Interface
- `WIDTH`, 8, word length in bits; legal range 2..32.
- `GAP`, 1, number of zero bits inserted after each word; legal range 0..15.
- `MSB_FIRST`, 1, bit order: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.

- `clk`  in  1  system clock; single clock domain, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `data_par`  in  WIDTH  word to serialize; sampled only when a load is accepted.
- `load`  in  1  load request; accepted on a rising edge where `load & ready`.
- `ready`  out  1  block can accept a word this cycle.
- `data_out`  out  1  serial bit stream to the detector's `data_in`.
- `busy`  out  1  a frame (data bits or gap bits) is in progress.
- `frame_end`  out  1  high while the last data bit of a word is on `data_out`.

## Operation
- Reset (`reset`=0) forces, asynchronously:
  - state to S_IDLE;
  - shift register and counters to 0;
  - outputs to `data_out`=0, `ready`=1, `busy`=0, `frame_end`=0.
- State machine:
  - **S_IDLE:** `data_out`=0 and `ready`=1. On an accepted load, capture `data_par` into the shift register, load the bit counter with WIDTH-1, and go to S_SHIFT.
  - **S_SHIFT:** `data_out` is the current bit and `busy`=1. Each cycle, shift by one position (direction set by MSB_FIRST) and decrement the counter.
    - On the cycle the counter is 0, `frame_end`=1.
    - Next state is S_GAP when GAP>0. When GAP=0 it is S_IDLE, or S_SHIFT with the new word if a load is accepted that cycle.
  - **S_GAP:** `data_out`=0 and `busy`=1 for exactly GAP cycles. On the last gap cycle, go to S_IDLE, or to S_SHIFT if a load is accepted that cycle.
- `ready` is high in these cycles only:
  - S_IDLE;
  - the last S_SHIFT cycle when GAP=0;
  - the last S_GAP cycle when GAP>0.
  
  This gives seamless back-to-back frames.
- A load while `ready`=0 is ignored; no word is queued and no error is flagged.
- `data_par` changes outside an accepted load have no effect.
- Counter widths: bit counter is $clog2(WIDTH) bits; gap counter is 4 bits.
- Reset asserted mid-frame aborts the frame immediately; the remaining bits are discarded.

## Timing
- All outputs are registered; there is no combinational path from `load` or `data_par` to `data_out`.
- A load accepted at rising edge k puts the first bit on `data_out` after edge k and holds it until edge k+1.
- The last data bit occupies cycle k+WIDTH-1 relative to that first-bit cycle.
- Frame period is WIDTH+GAP cycles; with back-to-back loads, throughput is one word per WIDTH+GAP cycles.
- `ready` is valid in the same cycle the load is sampled. The stimulus drives `load` and `data_par` on the falling edge.

## Structure
- Shared package or include `fsm_ones_pkg`: state encodings S_IDLE=2'd0, S_SHIFT=2'd1, S_GAP=2'd2, plus the default WIDTH and GAP constants. The detector benches reuse these.
- No sub-module: a single module holding the FSM, shift register, bit counter and gap counter.
- Top-level integration: `data_out` connects to `data_in` of the detector, with `clk` and `reset` shared.

## Test plan
1. **Reset:** hold `reset`=0 for 2 cycles -> `data_out`=0, `ready`=1, `busy`=0, `frame_end`=0. Pulse `reset` low asynchronously mid-cycle -> outputs take these values immediately.
2. **Single word** (WIDTH=8, GAP=2, MSB_FIRST=1): load 8'hE0 -> `data_out` = 1,1,1,0,0,0,0,0 then 0,0. `frame_end` high in the 8th cycle, `ready` high in the 10th. The downstream detector asserts `detect` exactly once.
3. **Load while busy:** load 8'hFF, then load 8'h00 in the 3rd data cycle -> the second load is ignored, the output is eight 1s then the gap, and `busy` falls after 10 cycles.
4. **Back-to-back** (GAP=0): load 8'hB7 then 8'h6E with `load` held -> 16 contiguous bits 1011011101101110. `ready` is high only in cycles 8 and 16. There are no idle bits between words.
5. **LSB first** (MSB_FIRST=0, GAP=1): load 8'h01 -> `data_out` = 1 followed by seven 0s, then one gap 0.
6. **Reset mid-frame:** load 8'hFF, assert `reset` during bit 4 -> `data_out` drops to 0 at once. After release, `ready`=1 and a new load of 8'h0F serializes cleanly as 0,0,0,0,1,1,1,1.
